acc_buffer: RTL and testbench
=============================

// Module: acc_buffer
// PURPOSE
//   Parametrised capture/accumulate buffer for systolic-array column outputs.
//   Stores DEPTH results of DATA_W bits, written in arrival order. Each result
//   either overwrites its slot or is added to it, so partial sums combine
//   across passes. Raises a registered full flag and a one-cycle snapshot of
//   all slots on the edge that writes the last slot. A registered random-read
//   port feeds the downstream unified buffer.
// PARAMETERS
//   DATA_W  32  width of each input and stored entry (two's complement)
//   DEPTH   4   number of entries, >= 2; AW = $clog2(DEPTH) derived internally
// PORTS
//   clk        in   1             rising-edge clock
//   reset_n    in   1             asynchronous active-low reset
//   in_valid   in   1             in_data is valid this cycle
//   in_data    in   DATA_W        result from the array column
//   accumulate in   1             1: slot <= slot + in_data; 0: slot <= in_data
//   restart    in   1             sync; pointer/full/overflow -> 0, data kept
//   clear      in   1             sync; as restart, and all slots -> 0
//   rd_en      in   1             read request
//   rd_addr    in   AW            read slot index
//   rd_data    out  DATA_W        registered read data
//   rd_valid   out  1             rd_data valid (1-cycle pulse per rd_en)
//   snap_data  out  DEPTH*DATA_W  all slots; slot i at [i*DATA_W +: DATA_W]
//   snap_valid out  1             1-cycle pulse when snap_data updates
//   full       out  1             all DEPTH slots written this pass
//   count      out  AW+1          slots written this pass, 0..DEPTH
//   overflow   out  1             sticky; a write arrived while full
// BEHAVIOUR
//   - Reset (reset_n=0, async): all slots, pointer, count, rd_data,
//     snap_data = 0. full, overflow, rd_valid and snap_valid = 0.
//   - A write occurs when in_valid=1 and full=0. Writes go to slot[count].
//     count increments by 1. A zero in_data value is a legal write.
//   - Arithmetic: accumulate=1 adds modulo 2^DATA_W (wraps, no saturation).
//     accumulate is sampled per write.
//   - On the write to slot DEPTH-1, on the same edge:
//       full <= 1; count <= DEPTH; snap_valid <= 1;
//       snap_data <= all slots, including the value just written.
//     full is therefore visible in the cycle after the last write.
//   - While full=1: in_valid is dropped (no slot change) and overflow <= 1.
//     full holds until restart or clear.
//   - snap_valid goes high only on the filling edge; it is 0 otherwise.
//     snap_data holds its value until the next fill, clear, or reset.
//   - restart: count <= 0, full <= 0, overflow <= 0. Slots are kept, so the
//     next pass with accumulate=1 sums onto the previous pass.
//   - clear: same as restart, and also all slots <= 0 and snap_data <= 0.
//   - Priority in the same cycle: clear > restart > write. A write
//     coinciding with restart/clear is discarded.
//   - Read: rd_en=1 -> on the next edge rd_data <= slot[rd_addr] and
//     rd_valid <= 1 (latency 1). rd_addr >= DEPTH returns 0 (rd_valid still 1).
//     A read and a write to the same slot in one cycle return the pre-write
//     value. When rd_en=0: rd_valid <= 0 and rd_data holds.
//   - Reset asserted mid-pass: everything clears immediately. The first
//     write after release goes to slot 0.
// TESTING
//   1. DEPTH=4, accumulate=0; write 5,0,7,9 on consecutive cycles
//      -> full=1 and snap_valid=1 in cycle 5; snap_data={9,7,0,5};
//         count=4; no extra snap_valid pulse afterwards.
//   2. Continuing from 1: in_valid with 3 while full
//      -> slots unchanged; overflow=1 stays set; restart -> full=0,
//         overflow=0, count=0.
//   3. After restart, accumulate=1; write 1,1,1,1
//      -> snap_data={10,8,1,6}. Then clear -> all slots 0, snap_data=0.
//   4. Wrap: slot0 holds 32'hFFFF_FFFF; accumulate 2 into it
//      -> slot0 = 1; overflow stays 0.
//   5. clear and in_valid in the same cycle
//      -> write discarded, count=0. rd_en with rd_addr=1 on a write to
//         slot1 -> rd_data is the old value, rd_valid=1 one cycle later.
//   6. Assert reset_n=0 for one cycle after 2 writes
//      -> all outputs 0 at once; the next write lands in slot 0 (rd check).

Source files
------------

// File: rtl/acc_buffer_if.sv
// Bundle between a systolic column, the accumulate buffer and the unified-buffer read side.
interface acc_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    accumulate;
  logic                    restart;
  logic                    clear;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [DEPTH*DATA_W-1:0] snap_data;
  logic                    snap_valid;
  logic                    full;
  logic [AW:0]             count;
  logic                    overflow;

  modport master (
    output in_valid, in_data, accumulate, restart, clear, rd_en, rd_addr,
    input  rd_data, rd_valid, snap_data, snap_valid, full, count, overflow
  );

  modport slave (
    input  in_valid, in_data, accumulate, restart, clear, rd_en, rd_addr,
    output rd_data, rd_valid, snap_data, snap_valid, full, count, overflow
  );
endinterface

// File: rtl/acc_buffer.sv
// Capture/accumulate buffer for systolic column results: in-order slot writes,
// overwrite-or-add per write, fill snapshot and a registered random-read port.
module acc_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              we,
  input  logic              acc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt
);
  // nxt is exported so the fill snapshot can include the value being written
  always_comb begin
    nxt = q;
    if (clr)     nxt = '0;
    else if (we) nxt = acc ? q + din : din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= nxt;
  end
endmodule

module acc_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic         clk,
  input logic         reset_n,
  acc_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef struct packed {
    logic              vld;
    logic              acc;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t                      wr;
  logic [DEPTH-1:0][DATA_W-1:0] slot_q;
  logic [DEPTH-1:0][DATA_W-1:0] slot_nxt;
  logic [CW-1:0]                count_q;
  logic                         full_q;
  logic                         ovf_q;
  logic                         fill;
  logic [DEPTH*DATA_W-1:0]      snap_q;
  logic                         snapv_q;
  logic [DATA_W-1:0]            rd_mux;
  logic [DATA_W-1:0]            rd_q;
  logic                         rdv_q;

  // clear and restart both win over a coincident write
  assign wr.vld  = bus.in_valid & ~full_q & ~bus.clear & ~bus.restart;
  assign wr.acc  = bus.accumulate;
  assign wr.data = bus.in_data;
  assign fill    = wr.vld & (count_q == LAST);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    acc_slot #(.DATA_W(DATA_W)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (bus.clear),
      .we      (wr.vld && (count_q == CW'(gi))),
      .acc     (wr.acc),
      .din     (wr.data),
      .q       (slot_q[gi]),
      .nxt     (slot_nxt[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (bus.clear || bus.restart) begin
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (wr.vld) begin
      count_q <= count_q + CW'(1);
      if (fill) full_q <= 1'b1;
    end else if (bus.in_valid && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q  <= '0;
      snapv_q <= 1'b0;
    end else begin
      snapv_q <= fill;
      if (bus.clear) snap_q <= '0;
      else if (fill) snap_q <= slot_nxt;
    end
  end

  // out-of-range addresses match no slot and read as zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.rd_addr == AW'(i)) rd_mux = slot_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      rdv_q <= 1'b0;
    end else begin
      rdv_q <= bus.rd_en;
      if (bus.rd_en) rd_q <= rd_mux;
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.rd_valid   = rdv_q;
  assign bus.snap_data  = snap_q;
  assign bus.snap_valid = snapv_q;
  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_acc_buffer.sv
// Directed scenarios plus randomized traffic against a slot-array reference model.
module tb_acc_buffer;
  localparam int DW = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  acc_buffer_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
  acc_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  acc_buffer_if #(.DATA_W(8), .DEPTH(3)) bus3 ();
  acc_buffer #(.DATA_W(8), .DEPTH(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  int total = 0;
  int bad = 0;

  logic [DW-1:0]    m_slot [DP];
  int               m_cnt;
  bit               m_full, m_ovf, m_snapv, m_rdv;
  logic [DW-1:0]    m_rd;
  logic [DP*DW-1:0] m_snap;

  task automatic model_reset();
    foreach (m_slot[i]) m_slot[i] = '0;
    m_cnt = 0; m_full = 0; m_ovf = 0; m_snapv = 0; m_rdv = 0; m_rd = '0; m_snap = '0;
  endtask

  // one clock edge of the documented behaviour, from the pre-edge inputs
  task automatic model_edge();
    if (!reset_n) begin model_reset(); return; end
    m_snapv = 0;
    m_rdv = bus.rd_en;
    if (bus.rd_en) m_rd = (int'(bus.rd_addr) < DP) ? m_slot[bus.rd_addr] : '0;
    if (bus.clear) begin
      foreach (m_slot[i]) m_slot[i] = '0;
      m_snap = '0; m_cnt = 0; m_full = 0; m_ovf = 0;
    end else if (bus.restart) begin
      m_cnt = 0; m_full = 0; m_ovf = 0;
    end else if (bus.in_valid) begin
      if (m_full) m_ovf = 1;
      else begin
        m_slot[m_cnt] = bus.accumulate ? m_slot[m_cnt] + bus.in_data : bus.in_data;
        m_cnt++;
        if (m_cnt == DP) begin
          m_full = 1; m_snapv = 1;
          for (int i = 0; i < DP; i++) m_snap[i*DW +: DW] = m_slot[i];
        end
      end
    end
  endtask

  task automatic drv(bit v, logic [DW-1:0] d, bit acc, bit rs, bit cl, bit re, logic [1:0] ra);
    bus.in_valid = v; bus.in_data = d; bus.accumulate = acc;
    bus.restart = rs; bus.clear = cl; bus.rd_en = re; bus.rd_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", bus.full, bus.overflow); end
    total++; if (bus.snap_data !== '0 || bus.snap_valid !== 1'b0) begin bad++; $display("FAIL reset_snap got=%h/%b exp=0/0", bus.snap_data, bus.snap_valid); end
    total++; if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd got=%h/%b exp=0/0", bus.rd_data, bus.rd_valid); end
    @(posedge clk); #1 reset_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL post_reset_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4] = '{32'd5, 32'd0, 32'd7, 32'd9};
    for (int i = 0; i < 3; i++) begin
      drv(1, vals[i], 0, 0, 0, 0, 0);
      total++; if (bus.snap_valid !== 1'b0 || bus.full !== 1'b0) begin bad++; $display("FAIL fill_early w%0d got=%b%b exp=00", i, bus.snap_valid, bus.full); end
    end
    drv(1, vals[3], 0, 0, 0, 0, 0);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    total++; if (bus.snap_valid !== 1'b1) begin bad++; $display("FAIL fill_snapv got=%b exp=1", bus.snap_valid); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
    total++; if (bus.snap_data !== {32'd9, 32'd7, 32'd0, 32'd5}) begin bad++; $display("FAIL fill_snap got=%h exp=%h", bus.snap_data, {32'd9, 32'd7, 32'd0, 32'd5}); end
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.snap_valid !== 1'b0 || bus.full !== 1'b1) begin bad++; $display("FAIL fill_after got=%b%b exp=01", bus.snap_valid, bus.full); end
  endtask

  task automatic test_overflow_restart();
    logic [DW-1:0] e [4] = '{32'd5, 32'd0, 32'd7, 32'd9};
    drv(1, 3, 0, 0, 0, 0, 0);
    total++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin bad++; $display("FAIL ovf_set got=%b/%0d exp=1/4", bus.overflow, bus.count); end
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 1, 2'(i));
      total++; if (bus.rd_data !== e[i] || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL ovf_slot%0d got=%0d/%b exp=%0d/1", i, bus.rd_data, bus.rd_valid, e[i]); end
    end
    drv(0, 0, 0, 1, 0, 0, 0);
    total++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.count !== 3'd0) begin bad++; $display("FAIL restart got=%b%b/%0d exp=00/0", bus.full, bus.overflow, bus.count); end
    total++; if (bus.snap_data !== {32'd9, 32'd7, 32'd0, 32'd5}) begin bad++; $display("FAIL restart_snap_hold got=%h", bus.snap_data); end
  endtask

  task automatic test_accumulate_clear();
    for (int i = 0; i < 4; i++) drv(1, 1, 1, 0, 0, 0, 0);
    total++; if (bus.snap_data !== {32'd10, 32'd8, 32'd1, 32'd6} || bus.snap_valid !== 1'b1) begin bad++; $display("FAIL acc_snap got=%h/%b exp=%h/1", bus.snap_data, bus.snap_valid, {32'd10, 32'd8, 32'd1, 32'd6}); end
    drv(0, 0, 0, 0, 1, 0, 0);
    total++; if (bus.snap_data !== '0 || bus.count !== 3'd0 || bus.full !== 1'b0) begin bad++; $display("FAIL clear got=%h/%0d/%b exp=0/0/0", bus.snap_data, bus.count, bus.full); end
    drv(0, 0, 0, 0, 0, 1, 2'd2);
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL clear_slot2 got=%0d exp=0", bus.rd_data); end
  endtask

  task automatic test_wrap();
    drv(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(1, 32'd2, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 2'd0);
    total++; if (bus.rd_data !== 32'd1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL wrap got=%h/%b exp=1/0", bus.rd_data, bus.overflow); end
  endtask

  task automatic test_clear_priority();
    drv(0, 0, 0, 0, 1, 0, 0);
    drv(1, 32'd11, 0, 0, 0, 0, 0);
    drv(1, 32'd22, 0, 0, 1, 0, 0);
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL clr_wr_count got=%0d exp=0", bus.count); end
    drv(0, 0, 0, 0, 0, 1, 2'd0);
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL clr_wr_slot0 got=%0d exp=0", bus.rd_data); end
    drv(1, 32'd33, 0, 0, 0, 0, 0);
    drv(1, 32'd44, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 2'd0);
    total++; if (bus.rd_data !== 32'd33 || bus.count !== 3'd0) begin bad++; $display("FAIL rs_wr got=%0d/%0d exp=33/0", bus.rd_data, bus.count); end
  endtask

  task automatic test_read_collision();
    drv(1, 32'd55, 0, 0, 0, 0, 0);
    drv(1, 32'd66, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(1, 32'd1, 0, 0, 0, 0, 0);
    drv(1, 32'd77, 0, 0, 0, 1, 2'd1);
    total++; if (bus.rd_data !== 32'd66 || bus.rd_valid !== 1'b1) begin bad++; $display("FAIL coll_old got=%0d/%b exp=66/1", bus.rd_data, bus.rd_valid); end
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd66) begin bad++; $display("FAIL rd_hold got=%0d/%b exp=66/0", bus.rd_data, bus.rd_valid); end
    drv(0, 0, 0, 0, 0, 1, 2'd1);
    total++; if (bus.rd_data !== 32'd77 || bus.count !== 3'd2) begin bad++; $display("FAIL coll_new got=%0d/%0d exp=77/2", bus.rd_data, bus.count); end
  endtask

  task automatic test_midpass_reset();
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(1, 32'd8, 0, 0, 0, 0, 0);
    drv(1, 32'd9, 0, 0, 0, 1, 2'd1);
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    total++; if (bus.count !== 3'd0 || bus.rd_data !== '0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL async_rst got=%0d/%0d/%b exp=0/0/0", bus.count, bus.rd_data, bus.rd_valid); end
    drv(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    drv(1, 32'd42, 0, 0, 0, 0, 0);
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL rst_count got=%0d exp=1", bus.count); end
    drv(0, 0, 0, 0, 0, 1, 2'd0);
    total++; if (bus.rd_data !== 32'd42) begin bad++; $display("FAIL rst_slot0 got=%0d exp=42", bus.rd_data); end
    drv(0, 0, 0, 0, 0, 1, 2'd1);
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL rst_slot1 got=%0d exp=0", bus.rd_data); end
  endtask

  // DEPTH=3 instance: address 3 is outside the buffer
  task automatic test_oob_read();
    logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      bus3.in_valid = 1'b1; bus3.in_data = v[i];
      drv(0, 0, 0, 0, 0, 0, 0);
    end
    bus3.in_valid = 1'b0;
    total++; if (bus3.full !== 1'b1 || bus3.snap_data !== 24'h332211) begin bad++; $display("FAIL d3_fill got=%b/%h exp=1/332211", bus3.full, bus3.snap_data); end
    bus3.rd_en = 1'b1; bus3.rd_addr = 2'd2;
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus3.rd_data !== 8'h33) begin bad++; $display("FAIL d3_rd2 got=%h exp=33", bus3.rd_data); end
    bus3.rd_addr = 2'd3;
    drv(0, 0, 0, 0, 0, 0, 0);
    total++; if (bus3.rd_data !== 8'h00 || bus3.rd_valid !== 1'b1) begin bad++; $display("FAIL d3_oob got=%h/%b exp=00/1", bus3.rd_data, bus3.rd_valid); end
    bus3.rd_en = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 20));
      drv(($urandom_range(0, 3) != 0), d, 1'($urandom), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 31) == 0), 1'($urandom), 2'($urandom));
      total++;
      if (bus.count !== 3'(m_cnt) || bus.full !== m_full || bus.overflow !== m_ovf) begin
        bad++; $display("FAIL rnd_state n=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, bus.count, bus.full, bus.overflow, m_cnt, m_full, m_ovf);
      end
      total++;
      if (bus.snap_valid !== m_snapv || bus.snap_data !== m_snap) begin
        bad++; $display("FAIL rnd_snap n=%0d got=%b/%h exp=%b/%h", n, bus.snap_valid, bus.snap_data, m_snapv, m_snap);
      end
      total++;
      if (bus.rd_valid !== m_rdv || bus.rd_data !== m_rd) begin
        bad++; $display("FAIL rnd_rd n=%0d got=%b/%h exp=%b/%h", n, bus.rd_valid, bus.rd_data, m_rdv, m_rd);
      end
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.accumulate = 0; bus.restart = 0;
    bus.clear = 0; bus.rd_en = 0; bus.rd_addr = '0;
    bus3.in_valid = 0; bus3.in_data = '0; bus3.accumulate = 0; bus3.restart = 0;
    bus3.clear = 0; bus3.rd_en = 0; bus3.rd_addr = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow_restart();
    test_accumulate_clear();
    test_wrap();
    test_clear_priority();
    test_read_collision();
    test_midpass_reset();
    test_oob_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
